// File: rtl/fetch_unit_pkg.sv
// Purpose: shared types for the fetch slice: the 32-bit word, the fetch FSM
//          states and the {pc, instr} entry held by the instruction buffer.
package fetch_unit_pkg;

    typedef logic [31:0] word32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding
        WAIT = 2'd1,  // one live response expected
        DROP = 2'd2   // one stale response expected, discarded on arrival
    } fetch_state_t;

    typedef struct packed {
        word32_t pc;
        word32_t instr;
    } fetch_entry_t;

    localparam word32_t INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Purpose: instruction-memory request/response bundle.
// Ports:   imem_req_o/imem_addr_o driven by the fetch unit (master),
//          imem_valid_i/imem_data_i driven by the memory (slave).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic    imem_req_o;
    word32_t imem_addr_o;
    logic    imem_valid_i;
    word32_t imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_valid_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_valid_i,
        output imem_data_i
    );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Purpose: circular instruction buffer of 2**BUF_POW2 {pc, instr} entries with
//          synchronous flush; head entry presented combinationally.
// Ports:   clk_i, reset_i (async active-low), flush_i, wr_en_i/wr_entry_i,
//          rd_en_i (ignored when empty), head_o, count_o, empty_o.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int unsigned BUF_POW2 = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                wr_en_i,
    input  fetch_entry_t        wr_entry_i,
    input  logic                rd_en_i,
    output fetch_entry_t        head_o,
    output logic [BUF_POW2:0]   count_o,
    output logic                empty_o
);

    localparam int unsigned DEPTH = 1 << BUF_POW2;
    localparam int unsigned PW    = BUF_POW2;
    localparam int unsigned CW    = BUF_POW2 + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;
    logic           rd_fire;

    assign rd_fire = rd_en_i && (count_q != '0);

    // Storage and pointers; pointers wrap naturally at PW bits.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[tail_q] <= wr_entry_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (rd_fire) begin
                head_q <= head_q + PW'(1);
            end
            case ({wr_en_i, rd_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch front end: PC register, single-outstanding
//          imem request FSM with redirect/flush, feeding a small buffer.
// Ports:   clk_i, reset_i (async active-low); imem_bus (master side of
//          fetch_unit_if); redirect_i/redirect_pc_i; iq_read_i pops head;
//          iq_data_o/iq_pc_o head entry; iq_empty_o.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word32_t     RESET_PC = 32'h0000_0000,
    parameter int unsigned BUF_POW2 = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    fetch_unit_if.master imem_bus,
    input  logic         redirect_i,
    input  word32_t      redirect_pc_i,
    input  logic         iq_read_i,
    output word32_t      iq_data_o,
    output word32_t      iq_pc_o,
    output logic         iq_empty_o
);

    localparam int unsigned DEPTH = 1 << BUF_POW2;
    localparam int unsigned CW    = BUF_POW2 + 1;
    localparam int unsigned NW    = CW + 1;

    fetch_state_t   state_q, state_d;
    word32_t        pc_q, pc_d;
    logic           req_c;
    word32_t        addr_c;
    logic           wr_en_c;
    fetch_entry_t   wr_entry;
    fetch_entry_t   head;
    logic [CW-1:0]  buf_count;
    logic           buf_empty;
    logic [NW-1:0]  post_cnt;
    logic           has_room;
    logic           post_room;

    // Occupancy after this cycle's write and any same-cycle pop.
    assign post_cnt  = NW'(buf_count) + NW'(1) - NW'(iq_read_i && !buf_empty);
    assign has_room  = buf_count < CW'(DEPTH);
    assign post_room = post_cnt < NW'(DEPTH);

    // State and PC registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, PC and request; redirect dominates every other event.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_c   = 1'b0;
        addr_c  = pc_q;
        wr_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end else if (has_room) begin
                    req_c   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = imem_bus.imem_valid_i ? IDLE : DROP;
                end else if (imem_bus.imem_valid_i) begin
                    wr_en_c = 1'b1;
                    pc_d    = pc_q + INSTR_BYTES;
                    if (post_room) begin
                        req_c  = 1'b1;
                        addr_c = pc_q + INSTR_BYTES;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
                if (imem_bus.imem_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_entry = '{pc: pc_q, instr: imem_bus.imem_data_i};

    fetch_buffer #(
        .BUF_POW2 (BUF_POW2)
    ) u_buf (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .flush_i    (redirect_i),
        .wr_en_i    (wr_en_c),
        .wr_entry_i (wr_entry),
        .rd_en_i    (iq_read_i),
        .head_o     (head),
        .count_o    (buf_count),
        .empty_o    (buf_empty)
    );

    // The request is combinational in the IDLE state, so hold it low in reset.
    assign imem_bus.imem_req_o  = req_c && reset_i;
    assign imem_bus.imem_addr_o = addr_c;

    assign iq_data_o  = head.instr;
    assign iq_pc_o    = head.pc;
    assign iq_empty_o = buf_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit: directed scenarios plus random
//          reads/redirects/latencies against a transaction-level model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int      DEPTH  = 4;
    localparam word32_t RST_PC = 32'h0000_0000;

    logic    clk = 1'b0;
    logic    reset_i;
    logic    redirect_i;
    word32_t redirect_pc_i;
    logic    iq_read_i;
    word32_t iq_data_o;
    word32_t iq_pc_o;
    logic    iq_empty_o;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (RST_PC),
        .BUF_POW2 (2)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .imem_bus      (bus),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .iq_read_i     (iq_read_i),
        .iq_data_o     (iq_data_o),
        .iq_pc_o       (iq_pc_o),
        .iq_empty_o    (iq_empty_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: queue contents, next PC, and whether a (possibly stale)
    // response is still owed by memory.
    word32_t mq_pc[$];
    word32_t mq_in[$];
    word32_t m_pc;
    bit      m_busy;
    bit      m_stale;

    // Memory stand-in: one pending response with a countdown.
    bit      mem_pend;
    int      mem_cnt;
    word32_t mem_addr;
    int      lat_cfg;

    logic    obs_req;
    word32_t obs_addr;
    word32_t req_log[$];

    function automatic word32_t mem_word(input word32_t a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: drive at negedge, check against model, advance at posedge.
    task automatic cycle(input logic rd, input logic redir, input word32_t rpc, input logic fv);
        logic    v;
        logic    exp_req;
        word32_t exp_addr;
        word32_t d;
        int      sz;
        int      lat;
        @(negedge clk);
        v = (mem_pend && mem_cnt == 0) || fv;
        d = (mem_pend && mem_cnt == 0) ? mem_word(mem_addr) : $urandom();
        iq_read_i        = rd;
        redirect_i       = redir;
        redirect_pc_i    = rpc;
        bus.imem_valid_i = v;
        bus.imem_data_i  = d;
        #1;
        sz = mq_pc.size();
        if (redir)                 exp_req = 1'b0;
        else if (!m_busy)          exp_req = (sz < DEPTH);
        else if (!m_stale && v)    exp_req = ((sz + 1 - ((rd && sz > 0) ? 1 : 0)) < DEPTH);
        else                       exp_req = 1'b0;
        exp_addr = m_busy ? m_pc + 32'd4 : m_pc;
        chk("req", 32'(bus.imem_req_o), 32'(exp_req));
        if (exp_req) chk("addr", bus.imem_addr_o, exp_addr);
        chk("empty", 32'(iq_empty_o), 32'(sz == 0));
        if (sz > 0) begin
            chk("head_pc", iq_pc_o, mq_pc[0]);
            chk("head_data", iq_data_o, mq_in[0]);
        end
        obs_req  = bus.imem_req_o;
        obs_addr = bus.imem_addr_o;
        if (obs_req) req_log.push_back(obs_addr);
        @(posedge clk);
        if (redir) begin
            mq_pc.delete();
            mq_in.delete();
            m_pc = rpc;
            if (m_busy && v) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else if (m_busy) begin
                m_stale = 1'b1;
            end
        end else begin
            if (rd && sz > 0) begin
                void'(mq_pc.pop_front());
                void'(mq_in.pop_front());
            end
            if (m_busy && v) begin
                if (!m_stale) begin
                    mq_pc.push_back(m_pc);
                    mq_in.push_back(d);
                    m_pc = m_pc + 32'd4;
                end
                m_busy  = exp_req;
                m_stale = 1'b0;
            end else if (!m_busy && exp_req) begin
                m_busy  = 1'b1;
                m_stale = 1'b0;
            end
        end
        if (mem_pend && mem_cnt == 0) mem_pend = 1'b0;
        else if (mem_pend)            mem_cnt--;
        if (obs_req) begin
            lat      = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(5, 1));
            mem_pend = 1'b1;
            mem_addr = obs_addr;
            mem_cnt  = lat - 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i          = 1'b0;
        iq_read_i        = 1'b0;
        redirect_i       = 1'b0;
        bus.imem_valid_i = 1'b0;
        #1;
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_empty", 32'(iq_empty_o), 32'd1);
        chk("rst_data", iq_data_o, 32'd0);
        chk("rst_pc", iq_pc_o, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_i = 1'b1;
        mq_pc.delete();
        mq_in.delete();
        m_pc    = RST_PC;
        m_busy  = 1'b0;
        m_stale = 1'b0;
        mem_pend = 1'b0;
        req_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        word32_t rpc;
        reset_i          = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        iq_read_i        = 1'b0;
        bus.imem_valid_i = 1'b0;
        bus.imem_data_i  = '0;
        mem_pend         = 1'b0;
        mem_cnt          = 0;
        mem_addr         = '0;

        // Fill with 1-cycle memory, no reads.
        lat_cfg = 1;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        chk("fill_nreq", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("fill_addr", (req_log.size() > i) ? req_log[i] : 32'hFFFF_FFFF, 32'(4 * i));
        chk("fill_count", 32'(dut.buf_count), 32'd4);
        chk("fill_noreq", 32'(obs_req), 32'd0);

        // One pop from full yields exactly one new request.
        req_log.delete();
        cycle(1'b1, 1'b0, '0, 1'b0);
        #1;
        chk("pop_head_pc", iq_pc_o, 32'h4);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        chk("pop_nreq", 32'(req_log.size()), 32'd1);
        chk("pop_addr", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h10);

        // Redirect while a slow request is outstanding.
        do_reset();
        lat_cfg = 5;
        cycle(1'b0, 1'b1, 32'h8, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("slow_req", 32'(obs_req), 32'd1);
        chk("slow_addr", obs_addr, 32'h8);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 32'h100, 1'b0);
        #1;
        chk("drop_state", 32'(dut.state_q), 32'(DROP));
        chk("drop_empty", 32'(iq_empty_o), 32'd1);
        req_log.delete();
        for (int k = 0; k < 20 && req_log.size() == 0; k++) cycle(1'b0, 1'b0, '0, 1'b0);
        chk("drop_nreq", 32'(req_log.size()), 32'd1);
        chk("drop_addr", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h100);

        // Redirect coincident with a response and a read.
        do_reset();
        lat_cfg = 1;
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 32'h200, 1'b0);
        #1;
        chk("coin_empty", 32'(iq_empty_o), 32'd1);
        chk("coin_state", 32'(dut.state_q), 32'(IDLE));
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("coin_req", 32'(obs_req), 32'd1);
        chk("coin_addr", obs_addr, 32'h200);

        // PC wrap past the top of the address space.
        do_reset();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("wrap_pc0", iq_pc_o, 32'hFFFF_FFFC);
        chk("wrap_data0", iq_data_o, mem_word(32'hFFFF_FFFC));
        cycle(1'b1, 1'b0, '0, 1'b0);
        #1;
        chk("wrap_pc1", iq_pc_o, 32'h0000_0000);

        // Reset mid-request, then a late response in the first post-reset cycle.
        do_reset();
        lat_cfg = 3;
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("late_req", 32'(obs_req), 32'd1);
        chk("late_addr", obs_addr, RST_PC);
        #1;
        chk("late_empty", 32'(iq_empty_o), 32'd1);

        // Random traffic.
        lat_cfg = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9, 0) == 0) rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3, 0));
            else                           rpc = $urandom() & 32'hFFFF_FFFC;
            cycle(1'($urandom_range(99, 0) < 40), 1'($urandom_range(99, 0) < 4), rpc, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter BUF_POW2, default 2: instruction buffer holds 2**BUF_POW2 entries (DEPTH).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 imem_req_o  output  1  one-cycle request pulse to instruction memory.
REQ-006 imem_addr_o  output  32  fetch address; valid while imem_req_o=1.
REQ-007 imem_valid_i  input  1  response strobe for the single outstanding request.
REQ-008 imem_data_i  input  32  instruction word; valid with imem_valid_i.
REQ-009 redirect_i  input  1  one-cycle PC redirect/flush request.
REQ-010 redirect_pc_i  input  32  new fetch PC; sampled when redirect_i=1.
REQ-011 iq_read_i  input  1  issue stage pops the head entry.
REQ-012 iq_data_o  output  32  head instruction word.
REQ-013 iq_pc_o  output  32  PC of the head instruction.
REQ-014 iq_empty_o  output  1  buffer holds no entries.

Function
REQ-015 Exactly one imem request SHALL be outstanding at a time; memory latency is >=1 cycle and unbounded.
REQ-016 FSM states SHALL be IDLE (no request outstanding), WAIT (one response expected), and DROP (stale response expected, to be discarded).
REQ-017 In IDLE, when count<DEPTH and redirect_i=0, the unit SHALL assert imem_req_o with imem_addr_o=pc and go to WAIT.
REQ-018 In WAIT with imem_valid_i=1 and redirect_i=0, the unit SHALL write {pc,imem_data_i} at tail and set pc=pc+4 (mod 2**32, wrapping).
REQ-019 In the same cycle as REQ-018, if post-write count<DEPTH, the unit SHALL assert imem_req_o for pc+4 and remain in WAIT; otherwise it SHALL go to IDLE.
REQ-020 Space is reserved at request time; a response SHALL never arrive to a full buffer.
REQ-021 Each cycle, iq_read_i=1 with buffer non-empty SHALL advance head; iq_read_i on empty SHALL be ignored.
REQ-022 A simultaneous read and write SHALL both take effect, leaving count unchanged.
REQ-023 iq_data_o and iq_pc_o SHALL present the head entry combinationally from registered storage; values are don't-care while iq_empty_o=1.
REQ-024 redirect_i=1 SHALL flush the buffer (count=0, head=tail), set pc=redirect_pc_i, and suppress imem_req_o that cycle; it overrides any same-cycle read or write.
REQ-025 A redirect in WAIT without imem_valid_i SHALL go to DROP; a redirect in WAIT with imem_valid_i SHALL discard that response and go to IDLE.
REQ-026 In DROP, imem_valid_i SHALL discard the data and go to IDLE; a further redirect in DROP SHALL update pc and remain in DROP.
REQ-027 No request SHALL be issued from DROP.
REQ-028 head/tail pointers SHALL wrap modulo DEPTH, and count SHALL range 0..DEPTH.

Reset
REQ-029 On reset_i=0, asynchronously: state=IDLE, pc=RESET_PC, head=tail=count=0, imem_req_o=0, iq_empty_o=1, iq_data_o=0, iq_pc_o=0.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding request; any response arriving after reset release while in IDLE SHALL be ignored.
REQ-031 After reset release, the first request SHALL occur on the first rising edge with the unit in IDLE.

Structure
REQ-032 word32_t SHALL be reused from data_types; fetch_state_t (IDLE/WAIT/DROP) and the fetch entry struct {pc,instr} SHALL be added to data_types.
REQ-033 The buffer MAY be a sub-module fetch_buffer (circular storage with flush) instantiated once; the FSM and PC SHALL stay in fetch_unit.
REQ-034 fetch_unit SHALL replace the PC register and instr_queue fifo in the core top; iq_* ports SHALL connect to issue_logic.

Verification
REQ-035 Reset, then 1-cycle-latency memory returning addr as data, no reads -> requests to 0x0,0x4,0x8,0xC; buffer full after 4 entries; imem_req_o stays 0.
REQ-036 Buffer full, then one iq_read_i -> exactly one new request to 0x10; head shows pc=0x4.
REQ-037 Request 0x8 outstanding (latency 5), redirect to 0x100 at cycle 2 -> state DROP, stale data discarded, next request to 0x100, buffer empty meanwhile.
REQ-038 Redirect to 0x200 coincident with imem_valid_i and iq_read_i -> response dropped, buffer empty, next request to 0x200.
REQ-039 Redirect to 0xFFFF_FFFC -> entries with pc 0xFFFF_FFFC then 0x0000_0000 (wrap).
REQ-040 Reset_i pulsed low mid-WAIT, then a late imem_valid_i -> no entry written; iq_empty_o=1; next request to RESET_PC.
